// File: rtl/axis_bus_demux_pkt_if.sv
// Bundle of the demux stream, select and status signals.
// slave is the demux's own view; master is the environment driving it.
// Widths follow the N_PORTS / DATA_W parameters of the demux.
interface axis_bus_demux_pkt_if #(
  parameter int N_PORTS = 10,
  parameter int DATA_W  = 32
);
  logic [7:0]          bus_sel;
  logic                s_axis_tvalid;
  logic                s_axis_tready;
  logic [DATA_W-1:0]   s_axis_tdata;
  logic [DATA_W/8-1:0] s_axis_tkeep;
  logic                s_axis_tlast;
  logic [N_PORTS-1:0]  m_axis_tvalid;
  logic [N_PORTS-1:0]  m_axis_tready;
  logic [DATA_W-1:0]   m_axis_tdata;
  logic [DATA_W/8-1:0] m_axis_tkeep;
  logic                m_axis_tlast;
  logic [15:0]         pkt_cnt;
  logic [15:0]         drop_cnt;
  logic                busy;

  modport slave (
    input  bus_sel, s_axis_tvalid, s_axis_tdata, s_axis_tkeep, s_axis_tlast, m_axis_tready,
    output s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast,
    output pkt_cnt, drop_cnt, busy
  );

  modport master (
    output bus_sel, s_axis_tvalid, s_axis_tdata, s_axis_tkeep, s_axis_tlast, m_axis_tready,
    input  s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast,
    input  pkt_cnt, drop_cnt, busy
  );
endinterface

// File: rtl/axis_bus_demux_pkt.sv
// Packet demux: first-beat bus_sel code (128+n) steers a whole packet to output n, else drops it.
// Latency: one cycle through a single-entry output register.
// Backpressure: forwarded beats stall only when the buffer is full and its port is not ready; dropped beats are always accepted.
module axis_bus_demux_pkt #(
  parameter int N_PORTS = 10,
  parameter int DATA_W  = 32
) (
  input logic              clk,
  input logic              rst,
  axis_bus_demux_pkt_if.slave bus
);
  localparam int KEEP_W = DATA_W / 8;
  localparam int TAG_W  = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
  localparam logic [7:0] N_PORTS_L = 8'(N_PORTS);

  typedef enum logic [1:0] {IDLE, FWD, DROP} state_t;

  state_t            state_q, state_d;
  logic [TAG_W-1:0]  port_q;
  logic [TAG_W-1:0]  sel_port;
  logic [TAG_W-1:0]  beat_port;
  logic              sel_valid;
  logic              fwd_beat;
  logic              s_rdy;
  logic              accept;
  logic              drain;
  logic              load;

  logic              full_q;
  logic [TAG_W-1:0]  tag_q;
  logic [DATA_W-1:0] dat_q;
  logic [KEEP_W-1:0] keep_q;
  logic              last_q;
  logic [15:0]       pkt_q;
  logic [15:0]       drop_q;

  // Decode the select code and decide whether the current beat is forwarded, and to where.
  always_comb begin
    sel_valid = bus.bus_sel[7] && ({1'b0, bus.bus_sel[6:0]} < N_PORTS_L);
    sel_port  = bus.bus_sel[TAG_W-1:0];
    fwd_beat  = 1'b0;
    beat_port = port_q;
    case (state_q)
      IDLE: begin
        fwd_beat  = sel_valid;
        beat_port = sel_port;
      end
      FWD:     fwd_beat = 1'b1;
      default: fwd_beat = 1'b0;
    endcase
  end

  // A forwarded beat can enter when the buffer is empty or emptying this cycle; drops never stall.
  assign drain  = full_q && bus.m_axis_tready[tag_q];
  assign s_rdy  = fwd_beat ? (!full_q || drain) : 1'b1;
  assign accept = bus.s_axis_tvalid && s_rdy;
  assign load   = accept && fwd_beat;

  // Packet FSM next state: the first beat's decision holds until tlast.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept && !bus.s_axis_tlast) state_d = sel_valid ? FWD : DROP;
      FWD:     if (accept && bus.s_axis_tlast) state_d = IDLE;
      DROP:    if (accept && bus.s_axis_tlast) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM state register and the port latched at packet start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      port_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept && state_q == IDLE) port_q <= sel_port;
    end
  end

  // Output buffer: load on forwarded accept (replaces a draining beat without a bubble), clear on drain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_q <= 1'b0;
      tag_q  <= '0;
      dat_q  <= '0;
      keep_q <= '0;
      last_q <= 1'b0;
    end else if (load) begin
      full_q <= 1'b1;
      tag_q  <= beat_port;
      dat_q  <= bus.s_axis_tdata;
      keep_q <= bus.s_axis_tkeep;
      last_q <= bus.s_axis_tlast;
    end else if (drain) begin
      full_q <= 1'b0;
    end
  end

  // Saturating packet counters, stepped when a packet's tlast beat is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pkt_q  <= '0;
      drop_q <= '0;
    end else if (accept && bus.s_axis_tlast) begin
      if (fwd_beat && pkt_q != 16'hFFFF) pkt_q <= pkt_q + 16'd1;
      if (!fwd_beat && drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
    end
  end

  // Only the tagged output sees valid.
  always_comb begin
    bus.m_axis_tvalid = '0;
    if (full_q) bus.m_axis_tvalid[tag_q] = 1'b1;
  end

  assign bus.s_axis_tready = s_rdy;
  assign bus.m_axis_tdata  = dat_q;
  assign bus.m_axis_tkeep  = keep_q;
  assign bus.m_axis_tlast  = last_q;
  assign bus.pkt_cnt       = pkt_q;
  assign bus.drop_cnt      = drop_q;
  assign bus.busy          = (state_q != IDLE) || full_q;
endmodule

// File: tb/tb_axis_bus_demux_pkt.sv
// Scoreboard bench for axis_bus_demux_pkt: packet-level model, randomized beats and output backpressure.
module tb_axis_bus_demux_pkt;
  localparam int NP = 10;
  localparam int DW = 32;

  typedef struct {
    int          port;
    logic [31:0] dat;
    logic [3:0]  keep;
    logic        last;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axis_bus_demux_pkt_if #(.N_PORTS(NP), .DATA_W(DW)) bus ();
  axis_bus_demux_pkt #(.N_PORTS(NP), .DATA_W(DW)) dut (.clk(clk), .rst(rst), .bus(bus));

  int    checks = 0;
  int    failures = 0;
  beat_t exp_q[$];
  int    m_pkt = 0;
  int    m_drop = 0;
  int    cyc = 0;
  int    rdy_mode = 0;     // 0: all ready, 1: random, 2: driven by the test
  bit    lat_chk = 0;
  int    lat_port = 0;
  logic [31:0] lat_dat = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc++;

  // Output ready generator.
  always @(posedge clk) begin
    #1;
    if (rdy_mode == 1) bus.m_axis_tready = NP'($urandom);
    else if (rdy_mode == 0) bus.m_axis_tready = '1;
  end

  // Monitor: every presented beat must be the scoreboard head; pop on handshake.
  bit          stall_prev = 0;
  logic [NP-1:0] prev_vld = '0;
  logic [31:0] prev_dat = '0;
  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 0;
      lat_chk = 0;
    end else begin
      if (lat_chk) begin
        chk("latency_vld", 64'(bus.m_axis_tvalid[lat_port]), 64'd1);
        chk("latency_dat", 64'(bus.m_axis_tdata), 64'(lat_dat));
        lat_chk = 0;
      end
      if (stall_prev) begin
        chk("stable_vld", 64'(bus.m_axis_tvalid), 64'(prev_vld));
        chk("stable_dat", 64'(bus.m_axis_tdata), 64'(prev_dat));
      end
      if (bus.m_axis_tvalid != '0) begin
        int p = -1;
        for (int i = 0; i < NP; i++) if (bus.m_axis_tvalid[i]) p = i;
        chk("onehot", 64'($onehot(bus.m_axis_tvalid)), 64'd1);
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_beat: port %0d data %0h with nothing expected", p, bus.m_axis_tdata);
        end else begin
          chk("out_port", 64'(p), 64'(exp_q[0].port));
          chk("out_data", 64'(bus.m_axis_tdata), 64'(exp_q[0].dat));
          chk("out_keep", 64'(bus.m_axis_tkeep), 64'(exp_q[0].keep));
          chk("out_last", 64'(bus.m_axis_tlast), 64'(exp_q[0].last));
          if (bus.m_axis_tready[p]) void'(exp_q.pop_front());
        end
      end
      stall_prev = (bus.m_axis_tvalid != '0) && ((bus.m_axis_tvalid & bus.m_axis_tready) == '0);
      prev_vld = bus.m_axis_tvalid;
      prev_dat = bus.m_axis_tdata;
    end
  end

  // Drive one beat until accepted; called and returns at posedge+1.
  task automatic send_beat(input logic [7:0] sel, input bit fwd, input int port, input logic last);
    logic [31:0] d;
    logic [3:0]  k;
    bit acc;
    int n;
    d = $urandom;
    k = 4'($urandom);
    acc = 0;
    n = 0;
    bus.bus_sel = sel;
    bus.s_axis_tdata = d;
    bus.s_axis_tkeep = k;
    bus.s_axis_tlast = last;
    bus.s_axis_tvalid = 1'b1;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = bus.s_axis_tready;
      if (!fwd) chk("drop_ready", 64'(acc), 64'd1);
      if (acc && fwd) exp_q.push_back('{port, d, k, last});
      @(posedge clk);
      #1;
      n++;
    end
    bus.s_axis_tvalid = 1'b0;
    if (!acc) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout: beat never accepted, sel %0d", sel);
    end else if (fwd) begin
      lat_chk = 1;
      lat_port = port;
      lat_dat = d;
    end
  endtask

  // Model: the first beat's code decides the whole packet.
  task automatic send_pkt(input logic [7:0] sel0, input logic [7:0] sel_mid, input int len);
    bit fwd;
    int port;
    fwd = (sel0 >= 8'd128) && (int'(sel0) < 128 + NP);
    port = int'(sel0) - 128;
    for (int i = 0; i < len; i++)
      send_beat((i == 0) ? sel0 : sel_mid, fwd, port, (i == len - 1));
    if (fwd) m_pkt++;
    else m_drop++;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout: %0d beats still expected", exp_q.size());
    end
    @(negedge clk);
    chk("busy_idle", 64'(bus.busy), 64'd0);
    chk("pkt_cnt", 64'(bus.pkt_cnt), 64'(m_pkt));
    chk("drop_cnt", 64'(bus.drop_cnt), 64'(m_drop));
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] rand_sel();
    int r;
    r = $urandom_range(0, 9);
    if (r < 7) return 8'(128 + $urandom_range(0, NP - 1));
    if (r == 7) return 8'd0;
    if (r == 8) return 8'd138;
    return 8'($urandom);
  endfunction

  task automatic check_reset_outputs();
    chk("rst_tvalid", 64'(bus.m_axis_tvalid), 64'd0);
    chk("rst_tdata", 64'(bus.m_axis_tdata), 64'd0);
    chk("rst_tkeep", 64'(bus.m_axis_tkeep), 64'd0);
    chk("rst_tlast", 64'(bus.m_axis_tlast), 64'd0);
    chk("rst_pkt_cnt", 64'(bus.pkt_cnt), 64'd0);
    chk("rst_drop_cnt", 64'(bus.drop_cnt), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_s_tready", 64'(bus.s_axis_tready), 64'd1);
  endtask

  initial begin
    int c0;
    bus.bus_sel = '0;
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tdata = '0;
    bus.s_axis_tkeep = '0;
    bus.s_axis_tlast = 1'b0;
    bus.m_axis_tready = '1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs();
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Four-beat packet to port 3.
    send_pkt(8'd131, 8'd131, 4);
    wait_drain();
    // Select changes mid-packet are ignored.
    send_pkt(8'd130, 8'd135, 3);
    wait_drain();
    // Zero code and out-of-range code are dropped.
    send_pkt(8'd0, 8'd0, 3);
    send_pkt(8'd138, 8'd138, 3);
    wait_drain();

    // Port 5 held not-ready for three cycles while other ports stay ready.
    rdy_mode = 2;
    bus.m_axis_tready = '1;
    bus.m_axis_tready[5] = 1'b0;
    fork
      send_pkt(8'd133, 8'd133, 3);
      begin
        repeat (2) @(negedge clk);
        chk("stall_s_tready", 64'(bus.s_axis_tready), 64'd0);
        chk("stall_tvalid", 64'(bus.m_axis_tvalid), 64'h20);
        @(negedge clk);
        chk("stall_s_tready2", 64'(bus.s_axis_tready), 64'd0);
        @(posedge clk);
        #1;
        bus.m_axis_tready[5] = 1'b1;
      end
    join
    rdy_mode = 0;
    wait_drain();

    // Back-to-back single-beat packets: one beat per cycle.
    c0 = cyc;
    send_pkt(8'd128, 8'd128, 1);
    send_pkt(8'd137, 8'd137, 1);
    chk("b2b_cycles", 64'(cyc - c0), 64'd2);
    wait_drain();

    // Randomized packets, codes and backpressure.
    rdy_mode = 1;
    for (int p = 0; p < 40; p++) begin
      logic [7:0] s0;
      s0 = rand_sel();
      send_pkt(s0, rand_sel(), $urandom_range(1, 5));
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #0;
    end
    rdy_mode = 0;
    wait_drain();

    // Reset during beat 2 of a five-beat packet.
    send_beat(8'd132, 1'b1, 4, 1'b0);
    send_beat(8'd132, 1'b1, 4, 1'b0);
    bus.s_axis_tdata = $urandom;
    bus.s_axis_tvalid = 1'b1;
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_reset_outputs();
    exp_q.delete();
    m_pkt = 0;
    m_drop = 0;
    bus.s_axis_tvalid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    send_pkt(8'd129, 8'd129, 3);
    wait_drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
